// File: rtl/fht_unload_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fht_unload_if : bank-read bus and sample stream of the FHT unloader |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface fht_unload_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic             iFHT_RDY;
  logic             iSOURCE_DATA;
  logic [D_BIT-1:0] iRD_DATA_0;
  logic [D_BIT-1:0] iRD_DATA_1;
  logic [D_BIT-1:0] iRD_DATA_2;
  logic [D_BIT-1:0] iRD_DATA_3;
  logic [A_BIT-1:0] oADDR_RD;
  logic             oRD_EN;
  logic             oBANK_SET;
  logic [D_BIT-1:0] oDATA;
  logic             oVALID;
  logic             iREADY;
  logic             oLAST;
  logic             oBUSY;
  logic             oDONE;
  logic             oABORT;

  modport master (
    input  iFHT_RDY, iSOURCE_DATA, iRD_DATA_0, iRD_DATA_1, iRD_DATA_2, iRD_DATA_3, iREADY,
    output oADDR_RD, oRD_EN, oBANK_SET, oDATA, oVALID, oLAST, oBUSY, oDONE, oABORT
  );

  modport slave (
    output iFHT_RDY, iSOURCE_DATA, iRD_DATA_0, iRD_DATA_1, iRD_DATA_2, iRD_DATA_3, iREADY,
    input  oADDR_RD, oRD_EN, oBANK_SET, oDATA, oVALID, oLAST, oBUSY, oDONE, oABORT
  );
endinterface
`default_nettype wire

// File: rtl/fht_unload.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fht_unload : streams the four FHT result banks out as one sequence  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fht_unload #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic          iCLK,
  input  logic          iRESET,
  fht_unload_if.master  bus
);
  localparam int               c_IDX_W     = A_BIT + 2;
  localparam logic [A_BIT-1:0] c_LAST_ADDR = {A_BIT{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_rdy_q;
  logic               r_cap;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_cnt;
  logic [c_IDX_W-1:0] r_idx;
  logic [A_BIT-1:0]   r_addr;
  logic [A_BIT-1:0]   r_next_addr;
  logic               r_rd_en;
  logic               r_bank_set;
  logic               r_done;
  logic               r_abort;
  logic [D_BIT-1:0]   r_buf [2][4];

  logic               w_rise;
  logic               w_abort;
  logic               w_valid;
  logic               w_hs;
  logic               w_pop;
  logic               w_last;
  logic               w_last_rd;
  logic               w_issue;
  logic [1:0]         w_cnt_next;

  assign w_rise     = bus.iFHT_RDY & ~r_rdy_q;
  assign w_abort    = (r_state != S_IDLE) & ~bus.iFHT_RDY;
  assign w_valid    = (r_cnt != 2'd0);
  assign w_hs       = w_valid & bus.iREADY;
  assign w_last     = &r_idx;
  assign w_pop      = w_hs & (&r_idx[1:0]);
  assign w_last_rd  = r_rd_en & (r_addr == c_LAST_ADDR);
  assign w_cnt_next = r_cnt + {1'b0, r_cap} - {1'b0, w_pop};
  // Entries held after this edge plus the read now on the bus must leave room for one more.
  assign w_issue    = (r_state == S_READ) & ~w_last_rd &
                      (({1'b0, w_cnt_next} + {2'b00, r_rd_en}) < 3'd2);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state     <= S_IDLE;
      r_rdy_q     <= 1'b1;
      r_cap       <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_rd_en     <= 1'b0;
      r_bank_set  <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_rdy_q <= bus.iFHT_RDY;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_abort) begin
        r_state  <= S_IDLE;
        r_abort  <= 1'b1;
        r_rd_en  <= 1'b0;
        r_cap    <= 1'b0;
        r_cnt    <= 2'd0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_idx    <= '0;
      end else begin
        r_cap <= r_rd_en;
        r_cnt <= w_cnt_next;
        if (r_cap) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        if (w_hs)  r_idx    <= r_idx + 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_state     <= S_READ;
              r_bank_set  <= bus.iSOURCE_DATA;
              r_addr      <= '0;
              r_next_addr <= A_BIT'(1);
              r_rd_en     <= 1'b1;
            end
          end
          S_READ: begin
            r_rd_en <= w_issue;
            if (w_issue) begin
              r_addr      <= r_next_addr;
              r_next_addr <= r_next_addr + 1'b1;
            end
            if (w_last_rd) r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (w_hs && w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_idx   <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // All four banks answer the same address, so one read fills a whole entry.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int e = 0; e < 2; e++) begin
        for (int w = 0; w < 4; w++) begin
          r_buf[e][w] <= '0;
        end
      end
    end else if (r_cap && !w_abort) begin
      r_buf[r_wr_ptr][0] <= bus.iRD_DATA_0;
      r_buf[r_wr_ptr][1] <= bus.iRD_DATA_1;
      r_buf[r_wr_ptr][2] <= bus.iRD_DATA_2;
      r_buf[r_wr_ptr][3] <= bus.iRD_DATA_3;
    end
  end

  assign bus.oADDR_RD  = r_addr;
  assign bus.oRD_EN    = r_rd_en;
  assign bus.oBANK_SET = r_bank_set;
  assign bus.oDATA     = r_buf[r_rd_ptr][r_idx[1:0]];
  assign bus.oVALID    = w_valid;
  assign bus.oLAST     = w_valid & w_last;
  assign bus.oBUSY     = (r_state != S_IDLE);
  assign bus.oDONE     = r_done;
  assign bus.oABORT    = r_abort;
endmodule
`default_nettype wire

// File: tb/tb_fht_unload.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fht_unload : scoreboard bench for fht_unload                     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fht_unload;
  localparam int A_BIT = 8;
  localparam int D_BIT = 16;
  localparam int N_SMP = 4 * (1 << A_BIT);

  logic clk;
  logic rst;
  logic fht_rdy;
  logic source;
  logic ready_main;
  logic rand_ready;
  logic rand_val;
  logic [D_BIT-1:0] ram_q [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = -10;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic prev_stall = 1'b0;
  logic prev_last;
  logic [D_BIT-1:0] prev_data;
  logic [D_BIT:0] exp_q [$];

  fht_unload_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_unload #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  assign bus.iFHT_RDY     = fht_rdy;
  assign bus.iSOURCE_DATA = source;
  assign bus.iREADY       = rand_ready ? rand_val : ready_main;
  assign bus.iRD_DATA_0   = ram_q[0];
  assign bus.iRD_DATA_1   = ram_q[1];
  assign bus.iRD_DATA_2   = ram_q[2];
  assign bus.iRD_DATA_3   = ram_q[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered bank RAM: word {set, 0, bank, addr}; junk when not read.
  always @(posedge clk or posedge rst) begin
    for (int b = 0; b < 4; b++) begin
      if (rst) ram_q[b] <= '0;
      else if (bus.oRD_EN) ram_q[b] <= {bus.oBANK_SET, 5'd0, 2'(b), bus.oADDR_RD};
      else ram_q[b] <= 16'hBAD0 ^ 16'(b);
    end
  end

  initial begin
    rand_val = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rand_val = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic set);
    for (int n = 0; n < N_SMP; n++) begin
      logic [9:0] nn;
      nn = 10'(n);
      exp_q.push_back({(n == N_SMP - 1), set, 5'd0, nn[1:0], nn[9:2]});
    end
  endtask

  task automatic clear_counts();
    hs_cnt = 0; rd_cnt = 0; done_cnt = 0; abort_cnt = 0;
    exp_q.delete();
  endtask

  task automatic start_unload(input logic set);
    fht_rdy = 1'b0;
    tick();
    clear_counts();
    push_run(set);
    source  = set;
    fht_rdy = 1'b1;
  endtask

  // Called at posedge+1 of the cycle that sees the start edge.
  task automatic wait_first_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus.oVALID) found = 1'b1;
    end
    check(tag, found, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < max_cyc && !idle; i++) begin
      @(negedge clk);
      if (!bus.oBUSY) idle = 1'b1;
    end
    check(tag, idle, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_samples(input string tag, input int count);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      if (hs_cnt >= count) hit = 1'b1;
    end
    check(tag, hit, 1'b1);
  endtask

  always @(negedge clk) begin
    logic [D_BIT:0] e;
    cyc++;
    if (!rst) begin
      if (bus.oRD_EN) rd_cnt++;
      if (bus.oABORT) abort_cnt++;
      if (bus.oVALID && bus.iREADY) begin
        check("scoreboard_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sample", {bus.oLAST, bus.oDATA}, e);
        end
        hs_cnt++;
        if (bus.oLAST) last_cyc = cyc;
      end
      if (bus.oDONE) begin
        done_cnt++;
        check("done_after_last", ((cyc - last_cyc) <= 1), 1'b1);
      end
      if (prev_stall && bus.iFHT_RDY)
        check("stall_hold", {bus.oVALID, bus.oLAST, bus.oDATA}, {1'b1, prev_last, prev_data});
      prev_stall = bus.oVALID && !bus.iREADY;
      prev_last  = bus.oLAST;
      prev_data  = bus.oDATA;
      if (bus.oBUSY) check("occupancy", ((rd_cnt - hs_cnt / 4) <= 2), 1'b1);
      else           check("idle_quiet", {bus.oRD_EN, bus.oVALID}, 2'b00);
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int bubbles;
    rst = 1'b1; fht_rdy = 1'b1; source = 1'b0; ready_main = 1'b1; rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bus.oADDR_RD, bus.oRD_EN, bus.oBANK_SET, bus.oDATA, bus.oVALID,
           bus.oLAST, bus.oBUSY, bus.oDONE, bus.oABORT}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("post_reset_idle", {bus.oBUSY, bus.oRD_EN, bus.oVALID}, 3'b000);
    end

    // Full unload, set B, sink always ready
    tick();
    start_unload(1'b1);
    wait_first_valid("first_valid_latency");
    check("bank_set_b", bus.oBANK_SET, 1'b1);
    bubbles = 0;
    for (int i = 0; i < N_SMP - 1; i++) begin
      @(negedge clk);
      if (!bus.oVALID) bubbles++;
    end
    check("no_bubbles", bubbles, 0);
    wait_idle("run1_idle", 20);
    check("run1_samples", hs_cnt, N_SMP);
    check("run1_reads", rd_cnt, N_SMP / 4);
    check("run1_done", done_cnt, 1);
    check("run1_no_abort", abort_cnt, 0);
    check("run1_queue_empty", exp_q.size(), 0);

    // Full unload, set A, random back-pressure
    tick();
    rand_ready = 1'b1;
    start_unload(1'b0);
    wait_first_valid("run2_first_valid");
    check("bank_set_a", bus.oBANK_SET, 1'b0);
    wait_idle("run2_idle", 8000);
    rand_ready = 1'b0;
    check("run2_samples", hs_cnt, N_SMP);
    check("run2_reads", rd_cnt, N_SMP / 4);
    check("run2_done", done_cnt, 1);
    check("run2_queue_empty", exp_q.size(), 0);

    // Abort near sample 500, then restart from n=0
    tick();
    start_unload(1'b1);
    wait_samples("run3_reach_500", 500);
    tick();
    fht_rdy = 1'b0;
    tick();
    @(negedge clk);
    check("abort_pulse", {bus.oABORT, bus.oVALID, bus.oBUSY}, 3'b100);
    tick();
    @(negedge clk);
    check("abort_single", bus.oABORT, 1'b0);
    check("abort_count", abort_cnt, 1);
    check("abort_no_done", done_cnt, 0);
    start_unload(1'b1);
    wait_first_valid("restart_first_valid");
    wait_idle("run3_idle", 2000);
    check("run3_samples", hs_cnt, N_SMP);
    check("run3_done", done_cnt, 1);
    check("run3_queue_empty", exp_q.size(), 0);

    // Asynchronous reset near sample 300
    tick();
    start_unload(1'b0);
    wait_samples("run4_reach_300", 300);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {bus.oADDR_RD, bus.oRD_EN, bus.oBANK_SET, bus.oDATA, bus.oVALID,
           bus.oLAST, bus.oBUSY, bus.oDONE, bus.oABORT}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_start_after_reset", {bus.oBUSY, bus.oDONE, bus.oABORT}, 3'b000);
    end
    check("reset_no_done", done_cnt, 0);
    check("reset_no_abort", abort_cnt, 0);

    // 1->0->1 glitch during an unload: abort at the fall, restart on the rise
    tick();
    start_unload(1'b1);
    wait_samples("run5_reach_100", 100);
    tick();
    fht_rdy = 1'b0;
    tick();
    fht_rdy = 1'b1;
    clear_counts();
    push_run(1'b1);
    wait_first_valid("glitch_restart_valid");
    wait_idle("run5_idle", 2000);
    check("glitch_abort_count", abort_cnt, 1);
    check("run5_samples", hs_cnt, N_SMP);
    check("run5_done", done_cnt, 1);
    check("run5_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fht_unload.md
FHT_UNLOAD -- requirements
Module: fht_unload

Interface
REQ-001 Parameters: A_BIT, default 8, bank address width; D_BIT, default 16, sample width; N_BANK fixed at 4, not a parameter.
REQ-002 Clock: iCLK, input, 1 bit; the single clock, all flops on its rising edge.
REQ-003 Reset: iRESET, input, 1 bit; asynchronous, active-high.
REQ-004 iFHT_RDY, input, 1 bit; transform-controller ready level; 0 while a transform runs, 1 when idle or done.
REQ-005 iSOURCE_DATA, input, 1 bit; result bank set at transform end: 0 = set A, 1 = set B.
REQ-006 iRD_DATA_0..iRD_DATA_3, input, D_BIT each; bank read data, registered RAM, valid exactly one cycle after the address.
REQ-007 oADDR_RD, output, A_BIT; common read address to all four banks.
REQ-008 oRD_EN, output, 1 bit; read strobe, one per issued read.
REQ-009 oBANK_SET, output, 1 bit; selects set A (0) or set B (1) for reads.
REQ-010 oDATA, output, D_BIT; streamed sample.
REQ-011 oVALID, output, 1; iREADY, input, 1; ready/valid stream handshake.
REQ-012 oLAST, output, 1 bit; high with the final sample, index 4*2^A_BIT-1.
REQ-013 oBUSY, output, 1 bit; high in any state other than IDLE.
REQ-014 oDONE, output, 1 bit; one-cycle pulse after the last sample transfers.
REQ-015 oABORT, output, 1 bit; one-cycle pulse when an unload is aborted.

Function
REQ-016 Start on a rising edge of iFHT_RDY, detected through a register reset to 1, so the idle-high level out of reset never triggers.
REQ-017 On start, latch iSOURCE_DATA into oBANK_SET, which holds until the next start.
REQ-018 Sample index n, 0..4*2^A_BIT-1, streams in ascending order.
REQ-019 Each index maps to bank n[1:0] and address n[A_BIT+1:2].
REQ-020 Issue one read per address; all four bank words are captured on one read.
REQ-021 The four captured words emit as bank 0, 1, 2, 3, one per handshake.
REQ-022 FSM states: IDLE, READ, DRAIN.
REQ-023 IDLE -> READ on start.
REQ-024 READ -> DRAIN after address 2^A_BIT-1 is issued.
REQ-025 DRAIN -> IDLE when the last sample handshakes (oVALID & iREADY & oLAST); pulse oDONE in the same cycle.
REQ-026 Buffer depth is two 4-word entries.
REQ-027 Issue a read only when buffered entries plus reads in flight is below 2.
REQ-028 No captured data is lost or duplicated under any iREADY pattern.
REQ-029 Throughput with iREADY held 1 is one sample per cycle; there are no bubbles after the first sample.
REQ-030 First oVALID rises no later than 3 cycles after the cycle that detects the start edge.
REQ-031 oDATA and oLAST hold stable while oVALID=1 and iREADY=0.
REQ-032 oVALID never drops without a handshake, except on abort or reset.
REQ-033 The word counter is A_BIT+2 bits and wraps to 0 only on return to IDLE.
REQ-034 Abort when iFHT_RDY falls to 0 while oBUSY=1: in that cycle, go to IDLE.
REQ-035 On abort, flush the buffer and in-flight read, drop oVALID, and pulse oABORT; oDONE is not asserted.
REQ-036 A rising edge of iFHT_RDY while oBUSY=1 is ignored.
REQ-037 oRD_EN is 0 outside READ.

Reset
REQ-038 On iRESET=1, asynchronously: FSM = IDLE; counters and buffer cleared.
REQ-039 On iRESET=1, all outputs are 0: oADDR_RD, oRD_EN, oBANK_SET, oDATA, oVALID, oLAST, oBUSY, oDONE, oABORT.
REQ-040 On iRESET=1, the edge-detect register is set to 1.
REQ-041 Reset asserted mid-unload ends the transfer with no oDONE and no oABORT pulse.

Verification
REQ-042 Release reset with iFHT_RDY=1 held for 100 cycles -> oBUSY=0, oRD_EN=0, oVALID=0 throughout.
REQ-043 iFHT_RDY 0->1 with iSOURCE_DATA=1 and iREADY=1 -> oBANK_SET=1; banks preloaded with value {bank, addr}; 1024 samples stream in order n=0..1023; oLAST on n=1023; oDONE one cycle later-or-same per REQ-025; 256 oRD_EN pulses total.
REQ-044 Same start, iREADY random at 50% -> all 1024 samples correct and in order; oDATA stable during every stall; at most 2 buffered entries.
REQ-045 iFHT_RDY drops to 0 at sample 500 -> oABORT pulses once, oVALID=0 next cycle, FSM in IDLE; the next 0->1 edge restarts from n=0.
REQ-046 iRESET pulsed at sample 300 -> all outputs 0 asynchronously; no oDONE; no start until a fresh 0->1 edge.
REQ-047 Second 1->0->1 pulse on iFHT_RDY during an unload, with iFHT_RDY back at 1 within a cycle -> abort at the fall; the rise in the following cycle starts a new unload from n=0.
